updown_counter_gen: RTL and testbench

UPDOWN_COUNTER_GEN -- requirements
Module: updown_counter_gen

---
 rtl/updown_counter_gen.sv | 157 +++++++++++++++
 tb/tb_updown_counter_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_gen.sv
// Up/down counter with prescaler, wrap or saturate bounds, binary or
// packed-BCD counting, sticky overflow, terminal-count pulse and a
// holdable display snapshot.
module updown_counter_gen #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,     // synchronous, active-high
    input  logic               en,
    input  logic               up,
    input  logic               down,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               sat_mode,
    input  logic               bcd_mode,
    input  logic               hold,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic [WIDTH-1:0]   snap,
    output logic               tc,
    output logic               ovf
);

    localparam int               DIGITS  = WIDTH / 4;
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BCD_MAX = {DIGITS{4'h9}};

    // Packed-BCD increment; returns {carry out of the top digit, result}.
    // A digit above 9 is treated like 9: it becomes 0 and carries.
    function automatic logic [WIDTH:0] bcd_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             c;
        logic [3:0]       d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    c           = 1'b1;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Packed-BCD decrement; returns {borrow out of the top digit, result}.
    // A digit above 9 is corrected to 9 and absorbs the borrow.
    function automatic logic [WIDTH:0] bcd_dec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             b;
        logic [3:0]       d;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b1;
                end else if (d > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    b           = 1'b0;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    logic [PRESC_W-1:0] pcnt;
    logic               tick;
    logic               step;
    logic [WIDTH:0]     inc_res;   // {hit upper bound, incremented value}
    logic [WIDTH:0]     dec_res;   // {hit lower bound, decremented value}
    logic [WIDTH-1:0]   max_val;
    logic [WIDTH-1:0]   count_nxt;
    logic               tc_nxt;
    logic               ovf_nxt;

    // Tick decode, step arithmetic and bound handling for the next count.
    // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
    always_comb begin
        tick      = en && (pcnt == presc);
        step      = tick && (up ^ down);
        max_val   = bcd_mode ? BCD_MAX : BIN_MAX;
        inc_res   = bcd_mode ? bcd_inc(count)
                             : ({1'b0, count} + (WIDTH+1)'(1));
        dec_res   = bcd_mode ? bcd_dec(count)
                             : {count == '0, count - WIDTH'(1)};
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = ovf;

        if (step) begin
            if (up) begin
                if (inc_res[WIDTH]) begin
                    count_nxt = sat_mode ? max_val : '0;
                    tc_nxt    = 1'b1;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = inc_res[WIDTH-1:0];
                    tc_nxt    = sat_mode && (inc_res[WIDTH-1:0] == max_val);
                end
            end else begin
                if (dec_res[WIDTH]) begin
                    count_nxt = sat_mode ? '0 : max_val;
                    tc_nxt    = 1'b1;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = dec_res[WIDTH-1:0];
                    tc_nxt    = sat_mode && (dec_res[WIDTH-1:0] == '0);
                end
            end
        end
    end

    // Prescaler, count, terminal-count pulse and sticky overflow registers.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pcnt  <= '0;
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            pcnt  <= '0;
            count <= load_val;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (en) begin
                pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
            end
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Display snapshot: follows count one edge late, frozen while hold is high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            snap <= '0;
        end else if (!hold) begin
            snap <= count;
        end
    end

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench for updown_counter_gen: decimal-arithmetic model
// compared every cycle, plus directed vectors with literal expectations.
module tb_updown_counter_gen;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               up;
    logic               down;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               sat_mode;
    logic               bcd_mode;
    logic               hold;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   snap;
    logic               tc;
    logic               ovf;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    updown_counter_gen #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .sat_mode (sat_mode),
        .bcd_mode (bcd_mode),
        .hold     (hold),
        .presc    (presc),
        .count    (count),
        .snap     (snap),
        .tc       (tc),
        .ovf      (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one step in decimal terms; returns {tc, overflow event, new count}.
    function automatic logic [9:0] model_step(input logic [7:0] cur, input logic go_up,
                                              input logic bcd, input logic sat);
        int         hi, lo, val, maxv, nv;
        logic       t, o;
        logic [7:0] e;
        hi   = int'(cur[7:4]);
        lo   = int'(cur[3:0]);
        maxv = bcd ? 99 : 255;
        t    = 1'b0;
        o    = 1'b0;
        if (go_up) begin
            val = bcd ? (((hi > 9) ? 9 : hi) * 10 + ((lo > 9) ? 9 : lo)) : int'(cur);
            if (val == maxv) begin
                t  = 1'b1;
                o  = 1'b1;
                nv = sat ? maxv : 0;
            end else begin
                nv = val + 1;
                t  = sat && (nv == maxv);
            end
        end else begin
            val = bcd ? (hi * 10 + lo) : int'(cur);
            if (val == 0) begin
                t  = 1'b1;
                o  = 1'b1;
                nv = sat ? 0 : maxv;
            end else begin
                nv = val - 1;
                t  = sat && (nv == 0);
            end
        end
        e = bcd ? 8'((nv / 10) * 16 + (nv % 10)) : 8'(nv);
        return {t, o, e};
    endfunction

    logic [7:0] m_count, m_snap;
    int         m_pcnt;
    logic       m_tc, m_ovf;
    logic [9:0] m_r;

    // Candidate step result for the current model state and inputs.
    always_comb m_r = model_step(m_count, up, bcd_mode, sat_mode);

    // Reference model state, advanced on each rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            m_count <= '0;
            m_snap  <= '0;
            m_pcnt  <= 0;
            m_tc    <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (!hold) m_snap <= m_count;
            if (load) begin
                m_count <= load_val;
                m_pcnt  <= 0;
                m_tc    <= 1'b0;
                m_ovf   <= 1'b0;
            end else begin
                m_tc <= 1'b0;
                if (en) begin
                    if (m_pcnt == int'(presc)) begin
                        m_pcnt <= 0;
                        if (up != down) begin
                            m_count <= m_r[7:0];
                            m_tc    <= m_r[9];
                            if (m_r[8]) m_ovf <= 1'b1;
                        end
                    end else begin
                        m_pcnt <= (m_pcnt + 1) % (1 << PRESC_W);
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("model count", count, m_count);
            check("model snap",  snap,  m_snap);
            check("model tc",    tc,    m_tc);
            check("model ovf",   ovf,   m_ovf);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0;
        load_val = '0; sat_mode = 1'b0; bcd_mode = 1'b0; hold = 1'b0; presc = '0;
        cyc(2);
        checking = 1'b1;
        check("reset count", count, 0);
        check("reset snap",  snap,  0);
        check("reset tc",    tc,    0);
        check("reset ovf",   ovf,   0);

        // Binary wrap
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 8'hFE;
        cyc(); check("load FE", count, 8'hFE); check("load tc", tc, 0);
        load = 1'b0; up = 1'b1;
        cyc(); check("wrap FF", count, 8'hFF); check("wrap FF tc", tc, 0);
        cyc(); check("wrap 00", count, 8'h00); check("wrap 00 tc", tc, 1); check("wrap ovf", ovf, 1);
        cyc(); check("wrap 01", count, 8'h01); check("wrap 01 tc", tc, 0); check("wrap ovf sticky", ovf, 1);

        // Saturate down
        up = 1'b0; load = 1'b1; load_val = 8'h01; sat_mode = 1'b1;
        cyc(); check("load clears ovf", ovf, 0);
        load = 1'b0; down = 1'b1;
        cyc(); check("sat 1 count", count, 0); check("sat 1 tc", tc, 1); check("sat 1 ovf", ovf, 0);
        cyc(); check("sat 2 count", count, 0); check("sat 2 tc", tc, 1); check("sat 2 ovf", ovf, 1);
        cyc(); check("sat 3 count", count, 0); check("sat 3 tc", tc, 1);

        // BCD wrap and borrow
        down = 1'b0; sat_mode = 1'b0; bcd_mode = 1'b1; load = 1'b1; load_val = 8'h98;
        cyc(); load = 1'b0; up = 1'b1;
        cyc(); check("bcd 99", count, 8'h99);
        cyc(); check("bcd 00", count, 8'h00); check("bcd wrap tc", tc, 1);
        cyc(); check("bcd 01", count, 8'h01);
        up = 1'b0; load = 1'b1; load_val = 8'h10;
        cyc(); load = 1'b0; down = 1'b1;
        cyc(); check("bcd 10->09", count, 8'h09);
        down = 1'b0;

        // Invalid BCD digit correction
        load = 1'b1; load_val = 8'h1A;
        cyc(); load = 1'b0; up = 1'b1;
        cyc(); check("bcd 1A up", count, 8'h20);
        up = 1'b0; load = 1'b1; load_val = 8'h1A;
        cyc(); load = 1'b0; down = 1'b1;
        cyc(); check("bcd 1A down", count, 8'h19);
        down = 1'b0;

        // BCD saturate up
        sat_mode = 1'b1; load = 1'b1; load_val = 8'h98;
        cyc(); load = 1'b0; up = 1'b1;
        cyc(); check("bcd sat 99", count, 8'h99); check("bcd sat land tc", tc, 1);
        cyc(); check("bcd sat hold", count, 8'h99); check("bcd sat ovf", ovf, 1);
        up = 1'b0;

        // Mode toggles leave count alone
        en = 1'b0; load = 1'b1; load_val = 8'h45;
        cyc(); load = 1'b0; bcd_mode = 1'b0; sat_mode = 1'b0;
        cyc(2); check("toggle keeps count", count, 8'h45);
        bcd_mode = 1'b1;
        cyc(); check("toggle back keeps count", count, 8'h45);
        en = 1'b1;

        // up and down together
        up = 1'b1; down = 1'b1;
        cyc(5); check("up+down no step", count, 8'h45);
        up = 1'b0; down = 1'b0;

        // Load with up, prescaler restarts from 0
        bcd_mode = 1'b0; presc = 4'd3; load = 1'b1; load_val = 8'h37; up = 1'b1;
        cyc(); check("load beats up", count, 8'h37);
        load = 1'b0;
        cyc(3); check("presc wait", count, 8'h37);
        cyc(); check("presc step", count, 8'h38);
        cyc(); presc = 4'd1;
        cyc(); check("presc change", count, 8'h39);
        presc = 4'd3;

        // Reset together with load
        rst_n = 1'b1; load = 1'b1;
        cyc(); check("rst+load count", count, 0); check("rst+load snap", snap, 0);
        check("rst+load tc", tc, 0); check("rst+load ovf", ovf, 0);

        // Prescaler from reset, with an en gap
        rst_n = 1'b0; load = 1'b0; up = 1'b1;
        cyc(3); check("presc 3 edges", count, 0);
        cyc();  check("presc 4 edges", count, 1);
        cyc(4); check("presc 8 edges", count, 2);
        cyc(2); en = 1'b0;
        cyc(2); en = 1'b1;
        cyc();  check("en gap delays", count, 2);
        cyc();  check("en gap step", count, 3);

        // Snapshot hold
        presc = 4'd0;
        cyc(3); check("hold pre count", count, 6); check("hold pre snap", snap, 5);
        hold = 1'b1;
        cyc(3); check("hold count runs", count, 9); check("hold snap frozen", snap, 5);
        hold = 1'b0;
        cyc(); check("hold release snap", snap, 9);

        // Reset mid-hold drops the frozen snapshot
        hold = 1'b1;
        cyc(2); rst_n = 1'b1;
        cyc(); check("rst hold snap", snap, 0); check("rst hold count", count, 0);
        rst_n = 1'b0;
        cyc(2); check("post rst count", count, 2); check("post rst snap held", snap, 0);
        hold = 1'b0; up = 1'b0;
        cyc(2);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
